// File: rtl/ps2_defs.sv
`default_nettype none
// ==== ps2_defs : shared tag indices, set-2 special codes and ASCII constants | Rev 1.0 ====
package ps2_defs;

  localparam int TAG_RSHIFT = 5;
  localparam int TAG_RCTRL  = 4;
  localparam int TAG_RALT   = 3;
  localparam int TAG_LSHIFT = 2;
  localparam int TAG_LCTRL  = 1;
  localparam int TAG_LALT   = 0;

  localparam logic [7:0] CODE_CAPS  = 8'h58;
  localparam logic [7:0] CODE_SPACE = 8'h29;
  localparam logic [7:0] CODE_ENTER = 8'h5A;
  localparam logic [7:0] CODE_BKSP  = 8'h66;
  localparam logic [7:0] CODE_TAB   = 8'h0D;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_TAB = 8'h09;
  localparam logic [7:0] ASCII_SP  = 8'h20;

endpackage
`default_nettype wire

// File: rtl/ps2_set2_rom.sv
`default_nettype none
// ==== ps2_set2_rom : registered set-2 make code to ASCII lookup | Rev 1.0 ====
module ps2_set2_rom
  import ps2_defs::*;
(
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [7:0] code_i,
  input  logic       shift_i,
  input  logic       ctrl_i,
  input  logic       caps_i,
  output logic       hit_o,
  output logic [7:0] char_o
);

  logic       hit_d, hit_q;
  logic [7:0] char_d, char_q;
  logic [4:0] lidx;

  always_comb begin
    hit_d  = 1'b1;
    char_d = 8'h00;
    lidx   = 5'd0;
    case (code_i)
      8'h1C: lidx = 5'd1;   8'h32: lidx = 5'd2;   8'h21: lidx = 5'd3;
      8'h23: lidx = 5'd4;   8'h24: lidx = 5'd5;   8'h2B: lidx = 5'd6;
      8'h34: lidx = 5'd7;   8'h33: lidx = 5'd8;   8'h43: lidx = 5'd9;
      8'h3B: lidx = 5'd10;  8'h42: lidx = 5'd11;  8'h4B: lidx = 5'd12;
      8'h3A: lidx = 5'd13;  8'h31: lidx = 5'd14;  8'h44: lidx = 5'd15;
      8'h4D: lidx = 5'd16;  8'h15: lidx = 5'd17;  8'h2D: lidx = 5'd18;
      8'h1B: lidx = 5'd19;  8'h2C: lidx = 5'd20;  8'h3C: lidx = 5'd21;
      8'h2A: lidx = 5'd22;  8'h1D: lidx = 5'd23;  8'h22: lidx = 5'd24;
      8'h35: lidx = 5'd25;  8'h1A: lidx = 5'd26;
      8'h45: char_d = 8'h30;  8'h16: char_d = 8'h31;  8'h1E: char_d = 8'h32;
      8'h26: char_d = 8'h33;  8'h25: char_d = 8'h34;  8'h2E: char_d = 8'h35;
      8'h36: char_d = 8'h36;  8'h3D: char_d = 8'h37;  8'h3E: char_d = 8'h38;
      8'h46: char_d = 8'h39;
      CODE_SPACE: char_d = ASCII_SP;
      CODE_ENTER: char_d = ASCII_CR;
      CODE_BKSP:  char_d = ASCII_BS;
      CODE_TAB:   char_d = ASCII_TAB;
      default:    hit_d  = 1'b0;
    endcase
    // lidx is 1-based, so control codes are lidx itself and letters sit at 0x40/0x60 + lidx
    if (lidx != 5'd0) begin
      if (ctrl_i)
        char_d = {3'b000, lidx};
      else if (shift_i ^ caps_i)
        char_d = 8'h40 + {3'b000, lidx};
      else
        char_d = 8'h60 + {3'b000, lidx};
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      hit_q  <= 1'b0;
      char_q <= 8'h00;
    end else begin
      hit_q  <= hit_d;
      char_q <= char_d;
    end
  end

  assign hit_o  = hit_q;
  assign char_o = char_q;

endmodule
`default_nettype wire

// File: rtl/ps2_ascii_fifo.sv
`default_nettype none
// ==== ps2_ascii_fifo : PS/2 code -> ASCII translation feeding a FWFT FIFO | Rev 1.0 ====
module ps2_ascii_fifo
  import ps2_defs::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
)
(
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       iTrig,
  input  logic [7:0] iData,
  input  logic [5:0] iTag,
  input  logic       iRead,
  output logic [7:0] oData,
  output logic       oEmpty,
  output logic       oFull,
  output logic       oCaps,
  output logic       oDrop
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    code_q;
  logic          shift_q, ctrl_q, v1_q, v2_q, caps_q, caps_d;
  logic          pv_q, phit_q, drop_q, drop_d;
  logic [7:0]    pchar_q;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic          rom_hit, pop_ok, push_ok;
  logic [7:0]    rom_char;
  logic          unused_alt;

  assign unused_alt = iTag[TAG_RALT] ^ iTag[TAG_LALT];

  ps2_set2_rom u_rom (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .code_i  (code_q),
    .shift_i (shift_q),
    .ctrl_i  (ctrl_q),
    .caps_i  (caps_q),
    .hit_o   (rom_hit),
    .char_o  (rom_char)
  );

  always_comb begin
    pop_ok  = iRead & (count_q != '0);
    // a full FIFO still accepts the push when a pop frees a slot in the same cycle
    push_ok = pv_q & phit_q & ((count_q != FULL_CNT) | pop_ok);
    drop_d  = pv_q & (~phit_q | ((count_q == FULL_CNT) & ~pop_ok));
    caps_d  = caps_q ^ (v1_q & (code_q == CODE_CAPS));
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      code_q  <= 8'h00;
      shift_q <= 1'b0;
      ctrl_q  <= 1'b0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      caps_q  <= 1'b0;
      pv_q    <= 1'b0;
      phit_q  <= 1'b0;
      pchar_q <= 8'h00;
      drop_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      v1_q <= iTrig;
      if (iTrig) begin
        code_q  <= iData;
        shift_q <= iTag[TAG_RSHIFT] | iTag[TAG_LSHIFT];
        ctrl_q  <= iTag[TAG_RCTRL]  | iTag[TAG_LCTRL];
      end
      caps_q  <= caps_d;
      v2_q    <= v1_q & (code_q != CODE_CAPS);
      pv_q    <= v2_q;
      phit_q  <= rom_hit;
      pchar_q <= rom_char;
      drop_q  <= drop_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (push_ok)
      mem_q[wr_q] <= pchar_q;
  end

  assign oEmpty = (count_q == '0);
  assign oFull  = (count_q == FULL_CNT);
  assign oData  = oEmpty ? 8'h00 : mem_q[rd_q];
  assign oCaps  = caps_q;
  assign oDrop  = drop_q;

endmodule
`default_nettype wire

// File: doc/ps2_ascii_fifo.md
Name: ps2_ascii_fifo

Overview:
- Downstream consumer of the PS/2 keyboard decoder in the same PS/2 keyboard receive path.
- Samples each decoder pulse with its scan code (set 2 make code) and modifier tag vector, and translates the code to ASCII using the Shift, Ctrl and CapsLock state.
- Pushes translated characters into a small first-word-fall-through FIFO, which the application (e.g. SMG/LCD/UART demo) drains with a read strobe.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of 2.
- AW, 4, FIFO address width; log2(DEPTH).

Ports:
- CLOCK  input  1  system clock.
- RESET  input  1  asynchronous, active-low reset.
- iTrig  input  1  one-cycle pulse from the decoder; iData/iTag valid in that cycle.
- iData  input  8  set 2 make code.
- iTag  input  6  modifier flags: [5]RShift [4]RCtrl [3]RAlt [2]LShift [1]LCtrl [0]LAlt.
- iRead  input  1  pop strobe; ignored when oEmpty=1.
- oData  output  8  ASCII character at the FIFO head; valid while oEmpty=0.
- oEmpty  output  1  FIFO empty.
- oFull  output  1  FIFO holds DEPTH entries.
- oCaps  output  1  CapsLock state, for a keyboard/board LED.
- oDrop  output  1  one-cycle pulse: code unmapped, or push refused because FIFO full.

Behaviour:
- Reset (async, RESET=0):
  - FIFO pointers and count = 0, so oEmpty=1, oFull=0.
  - oCaps=0, oDrop=0, oData=8'h00; pipeline valid flags cleared.
  - Any in-flight code is lost.
- Derived modifiers:
  - shift = iTag[5] | iTag[2].
  - ctrl = iTag[4] | iTag[1].
  - Alt bits are ignored.
- Stage S1 (edge where iTrig=1): register code, shift and ctrl; set v1=1.
- Stage S2 (edge after S1): registered lookup in the sub-module. Output {hit, char}.
- CapsLock:
  - Code 8'h58 toggles oCaps in S2 and is not pushed; no oDrop.
  - The toggle takes effect for the next code; a back-to-back code in S1 uses the updated oCaps.
- Translation rules:
  - Letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A map to a..z.
  - Letter case: upper when shift XOR oCaps, else lower.
  - ctrl=1 with a letter gives 8'h01..8'h1A; overrides case.
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9'; shift and caps have no effect.
  - 29 maps to 8'h20, 5A to 8'h0D, 66 to 8'h08, 0D to 8'h09.
  - Any other code: no push, oDrop pulse.
- Push: in the cycle after S2 (stage P) when hit=1.
  - Latency: iTrig at edge n, character written at edge n+3, oEmpty falls after edge n+3.
- Pop: iRead=1 and oEmpty=0 advances the read pointer; oData shows the next entry in the following cycle (FWFT).
- Simultaneous push and pop:
  - When full, the push is accepted; count unchanged.
  - When empty, the pop is ignored and the push proceeds.
- Full without pop: push refused, oDrop=1 for 1 cycle, stored data unchanged.
- Pointers wrap modulo DEPTH; count is AW+1 bits wide.
- oFull = (count==DEPTH); oEmpty = (count==0).
- Throughput: one code per cycle. The decoder emits at most one per ~11 PS/2 clocks, so no backpressure is needed.
- oDrop: if an unmapped code and a full-refusal occur in the same cycle, a single pulse is produced.

Decomposition:
- Shared package/include `ps2_defs`:
  - Tag bit indices.
  - Special codes: 8'h58 CAPS, 8'h29, 8'h5A, 8'h66, 8'h0D.
  - ASCII constants CR, BS, TAB, SP.
- Sub-module `ps2_set2_rom`:
  - Registered lookup; inputs code, shift, ctrl, caps; outputs hit and char.
  - Purely a case table plus one register stage.
- The parent holds S1, the caps toggle, the FIFO storage/pointers and oDrop.

Test Plan:
- Reset then iTrig with 8'h1C, tag 0 -> oEmpty falls 3 cycles later, oData=8'h61; iRead -> oEmpty=1.
- 1C with tag 6'b000100, then 1C with tag 6'b100000 -> FIFO holds 8'h41, 8'h41.
- 58, then 1C (tag 0), then 1C (tag 6'b000100) -> oCaps=1, FIFO holds 8'h41, 8'h61; 58 pushes nothing.
- 1C with tag 6'b000010, then 16 with tag 6'b000100, then 05 -> FIFO holds 8'h01, 8'h31; 05 gives one oDrop pulse.
- 17 pushes of 29 with no read -> oFull=1 after 16; 17th gives oDrop, count stays 16; 16 reads return 8'h20 each, then oEmpty=1.
- Full FIFO with push and iRead in the same cycle -> count stays 16, no oDrop. Separately, assert RESET mid-pipeline -> all outputs return to reset values and no stale push occurs.
